// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the instruction sequencer.
//   - opcode/op field encodings of the instruction set
//   - sequencer state and instruction-class encodings
//   - mem_cmd, vsel and one-hot nsel output codes
//   - decode(): maps an opcode/op pair to the first post-DEC state
package cpu_ctrl_pkg;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RN   = 3'b100;

  typedef enum logic [4:0] {
    S_RST     = 5'd0,
    S_IF      = 5'd1,
    S_UPC     = 5'd2,
    S_DEC     = 5'd3,
    S_WAIT    = 5'd4,
    S_WR_IMM  = 5'd5,
    S_GET_A   = 5'd6,
    S_GET_B   = 5'd7,
    S_PASS    = 5'd8,
    S_ALU     = 5'd9,
    S_CMP     = 5'd10,
    S_WR_C    = 5'd11,
    S_ADDR    = 5'd12,
    S_LD_ADDR = 5'd13,
    S_MEM_RD  = 5'd14,
    S_WR_M    = 5'd15,
    S_GET_RD  = 5'd16,
    S_MEM_WR  = 5'd17,
    S_HALT    = 5'd18,
    S_ILL     = 5'd19
  } state_e;

  // Instruction class latched in DEC; it steers the shared states
  // (GET_A, GET_B, PASS, LD_ADDR) once opcode/op are no longer looked at.
  typedef enum logic [2:0] {
    K_MOV_REG = 3'd0,
    K_ALU     = 3'd1,
    K_CMP     = 3'd2,
    K_LDR     = 3'd3,
    K_STR     = 3'd4
  } kind_e;

  typedef struct packed {
    state_e next;
    kind_e  kind;
  } dec_t;

  function automatic dec_t decode(input logic [2:0] opcode, input logic [1:0] op);
    dec_t d;
    d.next = S_ILL;
    d.kind = K_ALU;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM) begin
          d.next = S_WR_IMM;
        end else if (op == OP_MOV_REG) begin
          d.next = S_GET_B;
          d.kind = K_MOV_REG;
        end
      end
      OPC_ALU: begin
        d.next = S_GET_A;
        case (op)
          OP_CMP:                 d.kind = K_CMP;
          OP_ADD, OP_AND, OP_MVN: d.kind = K_ALU;
        endcase
      end
      OPC_LDR: begin
        if (op == OP_MEM) begin
          d.next = S_GET_A;
          d.kind = K_LDR;
        end
      end
      OPC_STR: begin
        if (op == OP_MEM) begin
          d.next = S_GET_A;
          d.kind = K_STR;
        end
      end
      OPC_HALT: d.next = S_HALT;
      default:  d.next = S_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cpu_ctrl_wait_cnt.sv
// cpu_ctrl_wait_cnt: dwell counter for memory-read states.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : force the count to zero (has priority over inc_i)
//   inc_i      : advance the count by one
//   done_o     : count has reached MEM_WAIT (the final cycle of the dwell)
// MEM_WAIT is legal 0..3; the 2-bit counter cannot represent more.
module cpu_ctrl_wait_cnt #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic done_o
);

  localparam logic [1:0] LAST = 2'(MEM_WAIT);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: Moore sequencer for register file, ALU, PC and memory
// interface controls of the MOV/ADD/CMP/AND/MVN/LDR/STR/HALT datapath.
//   clk, reset        : clock, synchronous active-high reset
//   s                 : start (legacy mode, looked at only in WAIT)
//   opcode, op        : instruction fields, looked at only in DEC
//   w, halted, illegal: status (WAIT, HALT, one-cycle undefined-encoding pulse)
//   nsel, write, vsel : register-file select (one-hot), write enable, wb source
//   loada/b/c/s       : datapath register loads; asel/bsel ALU operand selects
//   load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd : fetch/memory controls
// AUTO_FETCH=1 fetches through PC/memory; 0 uses the s/w handshake.
// MEM_WAIT (0..3) is the number of extra cycles a memory read needs.
//
// state   | meaning
// --------+---------------------------------------------------------
// RST     | PC forced to 0 (auto-fetch reset state)
// IF      | instruction read at PC, MEM_WAIT+1 cycles, IR load on last
// UPC     | PC increment
// WAIT    | legacy idle, waiting for s (legacy reset state)
// DEC     | opcode/op sampled, instruction class latched
// WR_IMM  | Rn <= sximm8
// GET_A   | A <= Rn
// GET_B   | B <= Rm
// PASS    | C <= B (A forced to zero)
// ALU     | C <= A op B
// CMP     | status flags <= A - B
// WR_C    | Rd <= C
// ADDR    | C <= A + sximm5
// LD_ADDR | data address <= C
// MEM_RD  | data read at address, MEM_WAIT+1 cycles
// WR_M    | Rd <= mdata
// GET_RD  | B <= Rd (store data)
// MEM_WR  | data write, 1 cycle
// HALT    | stopped until reset
// ILL     | undefined encoding, one-cycle flag, no side effects
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter bit          AUTO_FETCH = 1'b1,
  parameter int unsigned MEM_WAIT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic       illegal
);

  localparam state_e S_BOOT = AUTO_FETCH ? S_RST : S_WAIT;
  // Where every finished instruction returns to.
  localparam state_e S_HOME = AUTO_FETCH ? S_IF : S_WAIT;

  state_e state_q, state_d;
  kind_e  kind_q, kind_d;
  dec_t   dec_w;
  logic   dwell;
  logic   wait_done;

  assign dec_w = decode(opcode, op);
  assign dwell = (state_q == S_IF) || (state_q == S_MEM_RD);

  // The counter sits at zero outside IF/MEM_RD and is zeroed again on the
  // last dwell cycle, so every entry into a dwell state starts from zero.
  cpu_ctrl_wait_cnt #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (!dwell || wait_done),
    .inc_i (dwell && !wait_done),
    .done_o(wait_done)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    case (state_q)
      S_RST:     state_d = S_IF;
      S_IF:      if (wait_done) state_d = S_UPC;
      S_UPC:     state_d = S_DEC;
      S_WAIT:    if (s) state_d = S_DEC;
      S_DEC: begin
        state_d = dec_w.next;
        kind_d  = dec_w.kind;
      end
      S_GET_A:   state_d = (kind_q == K_LDR || kind_q == K_STR) ? S_ADDR : S_GET_B;
      S_GET_B: begin
        case (kind_q)
          K_MOV_REG: state_d = S_PASS;
          K_CMP:     state_d = S_CMP;
          default:   state_d = S_ALU;
        endcase
      end
      S_PASS:    state_d = (kind_q == K_STR) ? S_MEM_WR : S_WR_C;
      S_ALU:     state_d = S_WR_C;
      S_ADDR:    state_d = S_LD_ADDR;
      S_LD_ADDR: state_d = (kind_q == K_LDR) ? S_MEM_RD : S_GET_RD;
      S_MEM_RD:  if (wait_done) state_d = S_WR_M;
      S_GET_RD:  state_d = S_PASS;
      S_HALT:    state_d = S_HALT;
      S_WR_IMM, S_WR_C, S_CMP, S_WR_M, S_MEM_WR, S_ILL: state_d = S_HOME;
      default:   state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      kind_q  <= K_ALU;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  always_comb begin
    w         = 1'b0;
    nsel      = NSEL_NONE;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = VSEL_C;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = wait_done;
      end
      S_UPC:  load_pc = 1'b1;
      S_WAIT: w = 1'b1;
      S_WR_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_PASS: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_ALU:  loadc = 1'b1;
      S_CMP:  loads = 1'b1;
      S_WR_C: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LD_ADDR: load_addr = 1'b1;
      S_MEM_RD:  mem_cmd = MEM_READ;
      S_WR_M: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_MDATA;
        write = 1'b1;
      end
      S_GET_RD: begin
        nsel  = NSEL_RD;
        loadb = 1'b1;
      end
      S_MEM_WR: mem_cmd = MEM_WRITE;
      S_HALT:   halted = 1'b1;
      S_ILL:    illegal = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller. Four instances cover both fetch modes and
// MEM_WAIT 0..3. For each instance the bench turns an instruction program
// into a per-cycle trace of (inputs to drive, outputs required) using the
// instruction timelines of the instruction set, then one process drives the
// trace and compares every meaningful cycle. opcode/op/s are randomised on
// every cycle where the controller must ignore them.
module tb_cpu_controller;

  localparam int NI = 4;
  // instance:           3     2     1     0
  localparam logic [NI-1:0]   AFV = 4'b1011;
  localparam logic [2*NI-1:0] MWV = {2'd3, 2'd0, 2'd2, 2'd1};

  localparam int NPROG = 12;
  localparam logic [2:0] POPC [NPROG] = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b110, 3'b110,
                                          3'b011, 3'b100, 3'b010, 3'b110, 3'b011, 3'b100};
  localparam logic [1:0] POP  [NPROG] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00,
                                          2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
  // DEC-to-last-state cycle counts; the LDR entry gets MEM_WAIT added.
  localparam int SPAN [NPROG] = '{5, 4, 5, 5, 2, 4, 6, 7, 2, 2, 2, 7};

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel;
    logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
    logic [1:0] mem_cmd;
    logic       halted, illegal;
  } out_t;

  typedef struct packed {
    out_t       exp;
    logic       chk, rst, sfix, sv, dec;
    logic [2:0] opc;
    logic [1:0] op;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_v, s_v;
  logic [2:0]    opc_v [NI];
  logic [1:0]    op_v  [NI];

  logic [NI-1:0] w_a, write_a, loada_a, loadb_a, loadc_a, loads_a, asel_a, bsel_a;
  logic [NI-1:0] load_ir_a, load_pc_a, reset_pc_a, load_addr_a, addr_sel_a, halted_a, illegal_a;
  logic [2:0]    nsel_a [NI];
  logic [1:0]    vsel_a [NI];
  logic [1:0]    mem_a  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cpu_controller #(
      .AUTO_FETCH(AFV[g]),
      .MEM_WAIT  (int'(MWV[2*g +: 2]))
    ) u_dut (
      .clk      (clk),
      .reset    (rst_v[g]),
      .s        (s_v[g]),
      .opcode   (opc_v[g]),
      .op       (op_v[g]),
      .w        (w_a[g]),
      .nsel     (nsel_a[g]),
      .write    (write_a[g]),
      .loada    (loada_a[g]),
      .loadb    (loadb_a[g]),
      .loadc    (loadc_a[g]),
      .loads    (loads_a[g]),
      .asel     (asel_a[g]),
      .bsel     (bsel_a[g]),
      .vsel     (vsel_a[g]),
      .load_ir  (load_ir_a[g]),
      .load_pc  (load_pc_a[g]),
      .reset_pc (reset_pc_a[g]),
      .load_addr(load_addr_a[g]),
      .addr_sel (addr_sel_a[g]),
      .mem_cmd  (mem_a[g]),
      .halted   (halted_a[g]),
      .illegal  (illegal_a[g])
    );
  end

  ent_t q [NI][$];
  int n_chk = 0;
  int n_pass = 0;
  int c_ill [NI];
  int c_wr  [NI];
  int c_mw  [NI];
  int c_halt[NI];

  function automatic int mw_of(input int i);
    return int'(MWV[2*i +: 2]);
  endfunction

  // Required outputs of each step of an instruction timeline.
  function automatic out_t stp(input string n);
    out_t o = '0;
    case (n)
      "RST":     begin o.reset_pc = 1; o.load_pc = 1; end
      "IF_WAIT": begin o.addr_sel = 1; o.mem_cmd = 2'b01; end
      "IF_LAST": begin o.addr_sel = 1; o.mem_cmd = 2'b01; o.load_ir = 1; end
      "UPC":     o.load_pc = 1;
      "WAIT":    o.w = 1;
      "WR_IMM":  begin o.nsel = 3'b100; o.vsel = 2'b01; o.write = 1; end
      "GET_A":   begin o.nsel = 3'b100; o.loada = 1; end
      "GET_B":   begin o.nsel = 3'b001; o.loadb = 1; end
      "PASS":    begin o.asel = 1; o.loadc = 1; end
      "ALU":     o.loadc = 1;
      "CMP":     o.loads = 1;
      "WR_C":    begin o.nsel = 3'b010; o.vsel = 2'b00; o.write = 1; end
      "ADDR":    begin o.bsel = 1; o.loadc = 1; end
      "LD_ADDR": o.load_addr = 1;
      "MEM_RD":  o.mem_cmd = 2'b01;
      "WR_M":    begin o.nsel = 3'b010; o.vsel = 2'b10; o.write = 1; end
      "GET_RD":  begin o.nsel = 3'b010; o.loadb = 1; end
      "MEM_WR":  o.mem_cmd = 2'b10;
      "HALT":    o.halted = 1;
      "ILL":     o.illegal = 1;
      default:   o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input int i, input string n, input bit rst = 0, input bit sfix = 0,
                      input bit sv = 0, input bit dec = 0, input logic [2:0] opc = 3'b0,
                      input logic [1:0] op = 2'b0, input bit chk = 1);
    ent_t e;
    e.exp  = stp(n);
    e.chk  = chk;
    e.rst  = rst;
    e.sfix = sfix;
    e.sv   = sv;
    e.dec  = dec;
    e.opc  = opc;
    e.op   = op;
    q[i].push_back(e);
  endtask

  task automatic fetch(input int i, input int idle);
    if (AFV[i]) begin
      for (int k = 0; k < mw_of(i); k++) push(i, "IF_WAIT");
      push(i, "IF_LAST");
      push(i, "UPC");
    end else begin
      for (int k = 0; k < idle; k++) push(i, "WAIT", 1'b0, 1'b1, 1'b0);
      push(i, "WAIT", 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic instr(input int i, input logic [2:0] opc, input logic [1:0] op,
                       output int len, input int idle);
    int n0;
    fetch(i, idle);
    n0 = q[i].size();
    push(i, "DEC", 1'b0, 1'b0, 1'b0, 1'b1, opc, op);
    if (opc == 3'b110 && op == 2'b10) begin
      push(i, "WR_IMM");
    end else if (opc == 3'b110 && op == 2'b00) begin
      push(i, "GET_B"); push(i, "PASS"); push(i, "WR_C");
    end else if (opc == 3'b101 && op == 2'b01) begin
      push(i, "GET_A"); push(i, "GET_B"); push(i, "CMP");
    end else if (opc == 3'b101) begin
      push(i, "GET_A"); push(i, "GET_B"); push(i, "ALU"); push(i, "WR_C");
    end else if (opc == 3'b011 && op == 2'b00) begin
      push(i, "GET_A"); push(i, "ADDR"); push(i, "LD_ADDR");
      for (int k = 0; k <= mw_of(i); k++) push(i, "MEM_RD");
      push(i, "WR_M");
    end else if (opc == 3'b100 && op == 2'b00) begin
      push(i, "GET_A"); push(i, "ADDR"); push(i, "LD_ADDR");
      push(i, "GET_RD"); push(i, "PASS"); push(i, "MEM_WR");
    end else begin
      push(i, "ILL");
    end
    len = q[i].size() - n0;
  endtask

  // LDR with reset raised in the first MEM_RD cycle.
  task automatic ldr_reset(input int i);
    fetch(i, 2);
    push(i, "DEC", 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 2'b00);
    push(i, "GET_A"); push(i, "ADDR"); push(i, "LD_ADDR");
    push(i, "MEM_RD", 1'b1);
    if (AFV[i]) push(i, "RST");
    else        push(i, "WAIT", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic halt(input int i, input int n);
    fetch(i, 2);
    push(i, "DEC", 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 2'b01);
    for (int k = 0; k < n; k++) push(i, "HALT");
  endtask

  task automatic lit(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, want);
  endtask

  function automatic bit busy();
    for (int i = 0; i < NI; i++) if (q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    ent_t e;
    for (int i = 0; i < NI; i++) begin
      if (q[i].size() == 0) begin
        rst_v[i] = 1'b1;
        s_v[i]   = 1'b0;
        opc_v[i] = 3'($urandom);
        op_v[i]  = 2'($urandom);
      end else begin
        e = q[i][0];
        rst_v[i] = e.rst;
        opc_v[i] = e.dec  ? e.opc : 3'($urandom);
        op_v[i]  = e.dec  ? e.op  : 2'($urandom);
        s_v[i]   = e.sfix ? e.sv  : 1'($urandom);
      end
    end
  endtask

  task automatic compare(input int cyc);
    ent_t e;
    out_t act;
    for (int i = 0; i < NI; i++) begin
      if (q[i].size() != 0) begin
        e = q[i].pop_front();
        act.w = w_a[i];             act.nsel = nsel_a[i];         act.write = write_a[i];
        act.loada = loada_a[i];     act.loadb = loadb_a[i];       act.loadc = loadc_a[i];
        act.loads = loads_a[i];     act.asel = asel_a[i];         act.bsel = bsel_a[i];
        act.vsel = vsel_a[i];       act.load_ir = load_ir_a[i];   act.load_pc = load_pc_a[i];
        act.reset_pc = reset_pc_a[i]; act.load_addr = load_addr_a[i];
        act.addr_sel = addr_sel_a[i]; act.mem_cmd = mem_a[i];
        act.halted = halted_a[i];   act.illegal = illegal_a[i];
        if (e.chk) begin
          n_chk++;
          if (act === e.exp) n_pass++;
          else $display("FAIL outputs dut%0d cycle %0d: got %h, required %h (w,nsel,write,loada,loadb,loadc,loads,asel,bsel,vsel,load_ir,load_pc,reset_pc,load_addr,addr_sel,mem_cmd,halted,illegal)",
                        i, cyc, act, e.exp);
          c_ill[i]  += int'(act.illegal);
          c_wr[i]   += int'(act.write);
          c_mw[i]   += int'(act.mem_cmd == 2'b10);
          c_halt[i] += int'(act.halted);
        end
      end
    end
  endtask

  initial begin
    int len;
    int cyc;
    for (int i = 0; i < NI; i++) begin
      c_ill[i] = 0; c_wr[i] = 0; c_mw[i] = 0; c_halt[i] = 0;
      // unchecked cycle: state is unknown until the first reset edge
      push(i, "RST", 1'b1, 1'b0, 1'b0, 1'b0, 3'b0, 2'b0, 1'b0);
      if (AFV[i]) push(i, "RST");
      for (int k = 0; k < NPROG; k++) begin
        instr(i, POPC[k], POP[k], len, (k == 0) ? 10 : 2);
        lit($sformatf("span dut%0d instr%0d", i, k), len, SPAN[k] + ((k == 6) ? mw_of(i) : 0));
      end
      ldr_reset(i);
      instr(i, 3'b110, 2'b10, len, 1);
      halt(i, 20);
    end

    cyc = 0;
    drive();
    while (busy() && cyc < 5000) begin
      @(negedge clk);
      compare(cyc);
      @(posedge clk);
      #1;
      drive();
      cyc++;
    end
    if (busy()) begin
      n_chk++;
      $display("FAIL timeout: trace not consumed after %0d cycles, required completion", cyc);
    end

    // Per-instance totals over the program: 3 undefined encodings,
    // 2 stores, 7 register writes, 20 halted cycles.
    for (int i = 0; i < NI; i++) begin
      lit($sformatf("illegal pulses dut%0d", i), c_ill[i], 3);
      lit($sformatf("mem writes dut%0d", i), c_mw[i], 2);
      lit($sformatf("reg writes dut%0d", i), c_wr[i], 7);
      lit($sformatf("halted cycles dut%0d", i), c_halt[i], 20);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
